// File: rtl/alu_decode_stage.sv
// RV32 R/I ALU decoder feeding a 2-entry output FIFO; illegal entries are counted on delivery.
// Latency 1 cycle; in_ready drops when both FIFO slots are occupied, output holds while out_ready=0.
// Backpressure: in_ready comes from registered occupancy only, so it never depends on out_ready.

module alu_decode_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         rdy_en;
    logic         push;
    logic         pop;

    // rdy_en keeps in_ready low during reset and raises it on the first edge afterwards
    assign push_rdy = rdy_en && (count != 2'd2);
    assign pop_vld  = (count != 2'd0);
    assign pop_dat  = mem[rd_ptr];
    assign push     = push_vld && push_rdy && !flush;
    assign pop      = pop_vld && pop_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= push_dat;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                if (push && !pop) begin
                    count <= count + 2'd1;
                end else if (pop && !push) begin
                    count <= count - 2'd1;
                end
            end
        end
    end
endmodule

module alu_decode_stage #(
    parameter int XLEN  = 32,
    parameter int EN_M  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       op,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm,
    output logic             use_imm,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_SLL = 5'd3;
    localparam logic [4:0] OP_SRL = 5'd7;
    localparam logic [4:0] OP_SRA = 5'd8;
    localparam logic [4:0] OP_MUL = 5'd16;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_M   = 7'b0000001;

    typedef struct packed {
        logic [4:0]      op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            illegal;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    dec_t       dec;
    dec_t       head;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] opcode;
    logic       legal;
    logic [4:0] dec_op;
    logic       dec_use_imm;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = 5'd4;
            3'b011:  base_op = 5'd5;
            3'b100:  base_op = 5'd6;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = 5'd9;
            default: base_op = 5'd10;
        endcase
    endfunction

    always_comb begin
        legal       = 1'b0;
        dec_op      = OP_NOP;
        dec_use_imm = 1'b0;
        if (opcode == OPC_R) begin
            if (funct7 == F7_STD) begin
                legal  = 1'b1;
                dec_op = base_op(funct3);
            end else if (funct7 == F7_ALT) begin
                if (funct3 == 3'b000) begin
                    legal  = 1'b1;
                    dec_op = OP_SUB;
                end else if (funct3 == 3'b101) begin
                    legal  = 1'b1;
                    dec_op = OP_SRA;
                end
            end else if (funct7 == F7_M && EN_M != 0) begin
                legal  = 1'b1;
                dec_op = OP_MUL + {2'b00, funct3};
            end
        end else if (opcode == OPC_I) begin
            // Shift immediates reuse the funct7 field as a qualifier; other I-ops take all 12 bits
            if (funct3 == 3'b001) begin
                legal  = (funct7 == F7_STD);
                dec_op = OP_SLL;
            end else if (funct3 == 3'b101) begin
                legal  = (funct7 == F7_STD) || (funct7 == F7_ALT);
                dec_op = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            end else begin
                legal  = 1'b1;
                dec_op = base_op(funct3);
            end
            dec_use_imm = 1'b1;
        end

        dec.op      = legal ? dec_op : OP_NOP;
        dec.use_imm = legal ? dec_use_imm : 1'b0;
        dec.illegal = !legal;
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.rd      = inst[11:7];
        dec.imm     = {{(XLEN-12){inst[31]}}, inst[31:20]};
    end

    alu_decode_fifo #(
        .W (DEC_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (dec),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head)
    );

    assign op      = head.op;
    assign rs1     = head.rs1;
    assign rs2     = head.rs2;
    assign rd      = head.rd;
    assign imm     = head.imm;
    assign use_imm = head.use_imm;
    assign illegal = head.illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (out_valid && out_ready && head.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: table-driven decode, backpressure, flush, counter saturation and async reset.
module tb_alu_decode_stage;
    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } dec_t;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  op;
        logic [4:0]  mop;
        logic        use_imm;
        logic        illegal;
        logic        millegal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, use_imm, illegal;
    logic [4:0]  op, rs1, rs2, rd;
    logic [31:0] imm;
    logic [15:0] illegal_cnt;

    logic        m_in_ready, m_out_valid, m_use_imm, m_illegal;
    logic [4:0]  m_op, m_rs1, m_rs2, m_rd;
    logic [31:0] m_imm;
    logic [1:0]  m_illegal_cnt;

    dec_t        obs;
    vec_t        vq[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_cnt = '0;
    logic [1:0]  exp_mcnt = '0;

    assign obs = {op, rs1, rs2, rd, imm, use_imm, illegal};

    always #5 clk = ~clk;

    alu_decode_stage #(.XLEN(32), .EN_M(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .use_imm(use_imm), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    alu_decode_stage #(.XLEN(32), .EN_M(1), .CNT_W(2)) dut_m (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .inst(inst),
        .out_valid(m_out_valid), .out_ready(out_ready),
        .op(m_op), .rs1(m_rs1), .rs2(m_rs2), .rd(m_rd), .imm(m_imm),
        .use_imm(m_use_imm), .illegal(m_illegal), .illegal_cnt(m_illegal_cnt)
    );

    function automatic vec_t mkv(input logic [31:0] i, input logic [4:0] o, input logic [4:0] mo,
                                 input logic u, input logic il, input logic mil);
        vec_t v;
        v.inst = i; v.op = o; v.mop = mo; v.use_imm = u; v.illegal = il; v.millegal = mil;
        return v;
    endfunction

    function automatic dec_t mk(input vec_t v);
        dec_t d;
        d.op      = v.op;
        d.rs1     = v.inst[19:15];
        d.rs2     = v.inst[24:20];
        d.rd      = v.inst[11:7];
        d.imm     = {{20{v.inst[31]}}, v.inst[31:20]};
        d.use_imm = v.use_imm;
        d.illegal = v.illegal;
        return d;
    endfunction

    task automatic test_reset;
        #1;
        tests++;
        if ({out_valid, in_ready, obs, illegal_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_state: got vld=%b rdy=%b dec=%h cnt=%h want all zero",
                     out_valid, in_ready, obs, illegal_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_decode;
        vec_t v[15];
        vec_t e;
        v[0]  = mkv(32'h002081B3, 5'd1,  5'd1,  1'b0, 1'b0, 1'b0);
        v[1]  = mkv(32'h022081B3, 5'd0,  5'd16, 1'b0, 1'b1, 1'b0);
        v[2]  = mkv(32'h402081B3, 5'd2,  5'd2,  1'b0, 1'b0, 1'b0);
        v[3]  = mkv(32'h4030D093, 5'd8,  5'd8,  1'b1, 1'b0, 1'b0);
        v[4]  = mkv(32'hFFF00293, 5'd1,  5'd1,  1'b1, 1'b0, 1'b0);
        v[5]  = mkv(32'h402091B3, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1);
        v[6]  = mkv(32'h0020C1B3, 5'd6,  5'd6,  1'b0, 1'b0, 1'b0);
        v[7]  = mkv(32'h0020D1B3, 5'd7,  5'd7,  1'b0, 1'b0, 1'b0);
        v[8]  = mkv(32'h0020F1B3, 5'd10, 5'd10, 1'b0, 1'b0, 1'b0);
        v[9]  = mkv(32'h02009093, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1);
        v[10] = mkv(32'h0010B093, 5'd5,  5'd5,  1'b1, 1'b0, 1'b0);
        v[11] = mkv(32'h00000000, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1);
        v[12] = mkv(32'h00309093, 5'd3,  5'd3,  1'b1, 1'b0, 1'b0);
        v[13] = mkv(32'h0220C1B3, 5'd0,  5'd20, 1'b0, 1'b1, 1'b0);
        v[14] = mkv(32'h0020A1B3, 5'd4,  5'd4,  1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (vq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL decode_extra: got unexpected entry %h want none", obs);
                end else begin
                    e = vq.pop_front();
                    tests++;
                    if (obs !== mk(e)) begin
                        fails++;
                        $display("FAIL decode %h: got %h want %h", e.inst, obs, mk(e));
                    end
                    tests++;
                    if (m_op !== e.mop || m_out_valid !== 1'b1) begin
                        fails++;
                        $display("FAIL decode_m %h: got op=%0d vld=%b want op=%0d vld=1",
                                 e.inst, m_op, m_out_valid, e.mop);
                    end
                    tests++;
                    if (illegal_cnt !== exp_cnt || m_illegal_cnt !== exp_mcnt) begin
                        fails++;
                        $display("FAIL illegal_cnt %h: got %0d/%0d want %0d/%0d",
                                 e.inst, illegal_cnt, m_illegal_cnt, exp_cnt, exp_mcnt);
                    end
                    if (e.illegal) exp_cnt = exp_cnt + 16'd1;
                    if (e.millegal && exp_mcnt != 2'd3) exp_mcnt = exp_mcnt + 2'd1;
                end
            end
            if (i < 15) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_ready: got %b want 1 at step %0d", in_ready, i);
                end
                in_valid = 1'b1;
                inst = v[i].inst;
                vq.push_back(v[i]);
            end else begin
                in_valid = 1'b0;
            end
        end
        tests++;
        if (vq.size() != 0 || out_valid !== 1'b0 || illegal_cnt !== exp_cnt || m_illegal_cnt !== 2'd3) begin
            fails++;
            $display("FAIL decode_end: got left=%0d vld=%b cnt=%0d mcnt=%0d want 0 0 %0d 3",
                     vq.size(), out_valid, illegal_cnt, m_illegal_cnt, exp_cnt);
        end
        vq.delete();
    endtask

    task automatic test_back_to_back;
        vec_t v[3];
        vec_t e;
        dec_t held;
        int   acc = 0;
        v[0] = mkv(32'h0020F1B3, 5'd10, 5'd10, 1'b0, 1'b0, 1'b0);
        v[1] = mkv(32'h0020C1B3, 5'd6,  5'd6,  1'b0, 1'b0, 1'b0);
        v[2] = mkv(32'h00309093, 5'd3,  5'd3,  1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (in_ready) begin
                vq.push_back(v[i]);
                acc++;
            end
            in_valid = 1'b1;
            inst = v[i].inst;
        end
        @(negedge clk);
        if (in_ready) begin
            vq.push_back(v[2]);
            acc++;
        end
        in_valid = 1'b0;
        tests++;
        if (acc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_full: got acc=%0d rdy=%b vld=%b want 2 0 1", acc, in_ready, out_valid);
        end
        held = obs;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (obs !== held || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_hold: got %h vld=%b want %h vld=1", obs, out_valid, held);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (out_valid && vq.size() != 0) begin
                e = vq.pop_front();
                tests++;
                if (obs !== mk(e)) begin
                    fails++;
                    $display("FAIL b2b_order %h: got %h want %h", e.inst, obs, mk(e));
                end
            end
            @(negedge clk);
        end
        tests++;
        if (vq.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got left=%0d vld=%b want 0 0", vq.size(), out_valid);
        end
        vq.delete();
    endtask

    task automatic test_flush;
        logic [15:0] cnt0;
        logic        seen = 1'b0;
        cnt0 = illegal_cnt;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; inst = 32'h00000000;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_fill: got vld=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_full: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        // One buffered entry plus an input the FIFO could otherwise accept
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (seen !== 1'b0 || illegal_cnt !== cnt0) begin
            fails++;
            $display("FAIL flush_discard: got seen=%b cnt=%0d want 0 %0d", seen, illegal_cnt, cnt0);
        end
    endtask

    task automatic test_saturate;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; inst = 32'h00000000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd3;
        tests++;
        if (illegal_cnt !== exp_cnt || m_illegal_cnt !== 2'd3) begin
            fails++;
            $display("FAIL saturate: got cnt=%0d mcnt=%0d want %0d 3", illegal_cnt, m_illegal_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; inst = 32'h002081B3;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || op !== 5'd1) begin
            fails++;
            $display("FAIL mid_pre: got vld=%b op=%0d want 1 1", out_valid, op);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({out_valid, in_ready, obs, illegal_cnt, m_illegal_cnt} !== '0) begin
            fails++;
            $display("FAIL mid_reset: got vld=%b rdy=%b dec=%h cnt=%0d mcnt=%0d want all zero",
                     out_valid, in_ready, obs, illegal_cnt, m_illegal_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_back_to_back;
        test_flush;
        test_saturate;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
